// File: rtl/oc8051_pt_pkg.sv
`default_nettype none
// ============================================================================
// Module   : oc8051_pt_pkg
// Purpose  : Shared constants for the page-table block and its bulk loader:
//            register map bases, image length and loader state encoding.
// Revision : 1.0  initial release
// ============================================================================
package oc8051_pt_pkg;

  // Page-table register map: 32 write-permission bytes then 32 read bytes
  localparam logic [15:0] PT_WR_BASE   = 16'hff80;
  localparam logic [15:0] PT_RD_BASE   = 16'hffa0;
  localparam int          PT_NUM_BYTES = 64;

  // Loader sequencer states
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_RD   = 3'd1;
  localparam logic [2:0] ST_WR   = 3'd2;
  localparam logic [2:0] ST_DONE = 3'd3;
  localparam logic [2:0] ST_ERR  = 3'd4;

  // Address of image byte idx relative to a 16-bit base (wraps mod 2^16)
  function automatic logic [15:0] pt_offset_addr(input logic [15:0] base,
                                                 input logic [5:0]  idx);
    return base + {10'd0, idx};
  endfunction

endpackage
`default_nettype wire

// File: rtl/oc8051_pt_bus_mux.sv
`default_nettype none
// ============================================================================
// Module   : oc8051_pt_bus_mux
// Purpose  : 2:1 page-table bus arbiter. While the loader owns the bus the CPU
//            is locked out (no ack); otherwise CPU accesses pass straight
//            through to the page table.
// Revision : 1.0  initial release
// ============================================================================
module oc8051_pt_bus_mux (
  input  logic        loader_own_i,
  input  logic        ld_stb_i,
  input  logic [15:0] ld_addr_i,
  input  logic [7:0]  ld_data_i,
  input  logic        ld_priv_i,
  input  logic        cpu_stb_i,
  input  logic [15:0] cpu_addr_i,
  input  logic [7:0]  cpu_data_i,
  input  logic        cpu_priv_i,
  output logic        cpu_ack_o,
  output logic        pt_stb_o,
  output logic [15:0] pt_addr_o,
  output logic [7:0]  pt_data_o,
  output logic        pt_priv_o,
  input  logic        pt_ack_i
);

  // Select bus owner; a CPU request during a load is dropped, not queued
  always_comb begin
    if (loader_own_i) begin
      pt_stb_o  = ld_stb_i;
      pt_addr_o = ld_addr_i;
      pt_data_o = ld_data_i;
      pt_priv_o = ld_priv_i;
      cpu_ack_o = 1'b0;
    end else begin
      pt_stb_o  = cpu_stb_i;
      pt_addr_o = cpu_addr_i;
      pt_data_o = cpu_data_i;
      pt_priv_o = cpu_priv_i;
      cpu_ack_o = pt_ack_i;
    end
  end

endmodule
`default_nettype wire

// File: rtl/oc8051_pt_loader.sv
`default_nettype none
// ============================================================================
// Module   : oc8051_pt_loader
// Purpose  : Copies a permission image from XRAM into the page-table registers
//            one byte at a time (read XRAM, write page table), holding the
//            page-table bus for the whole load so no CPU write interleaves.
//            Any single ack that takes TIMEOUT cycles aborts the load.
// Revision : 1.0  initial release
// ============================================================================
module oc8051_pt_loader
  import oc8051_pt_pkg::*;
#(
  parameter int          NUM_BYTES = PT_NUM_BYTES,
  parameter logic [15:0] PT_BASE   = PT_WR_BASE,
  parameter int          TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] src_base,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        mem_stb,
  output logic [15:0] mem_addr,
  input  logic [7:0]  mem_data,
  input  logic        mem_ack,
  input  logic        cpu_stb,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_data,
  input  logic        cpu_priv,
  output logic        cpu_ack,
  output logic        pt_stb,
  output logic [15:0] pt_addr,
  output logic [7:0]  pt_data,
  output logic        pt_priv,
  input  logic        pt_ack
);

  localparam logic [5:0] LAST_IDX  = 6'(NUM_BYTES - 1);
  // Watchdog value on the last permitted waiting cycle of a state visit
  localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 1);

  logic [2:0]  state_q, state_d;
  logic [5:0]  idx_q,   idx_d;
  logic [7:0]  wdog_q,  wdog_d;
  logic [7:0]  byte_q,  byte_d;
  logic [15:0] src_q,   src_d;

  logic        ld_stb;
  logic [15:0] ld_addr;
  logic [7:0]  ld_data;

  // Decode outputs from the current state; idle values are all zero
  always_comb begin
    busy     = (state_q != ST_IDLE);
    done     = (state_q == ST_DONE);
    err      = (state_q == ST_ERR);
    mem_stb  = (state_q == ST_RD);
    mem_addr = mem_stb ? pt_offset_addr(src_q, idx_q) : 16'h0000;
    ld_stb   = (state_q == ST_WR);
    ld_addr  = ld_stb ? pt_offset_addr(PT_BASE, idx_q) : 16'h0000;
    ld_data  = ld_stb ? byte_q : 8'h00;
  end

  // Sequencer next state: one XRAM read then one page-table write per byte
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wdog_d  = wdog_q;
    byte_d  = byte_q;
    src_d   = src_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          src_d   = src_base;
          idx_d   = 6'd0;
          wdog_d  = 8'd0;
          state_d = ST_RD;
        end
      end
      ST_RD: begin
        if (mem_ack) begin
          byte_d  = mem_data;
          wdog_d  = 8'd0;
          state_d = ST_WR;
        end else if (wdog_q == WDOG_LAST) begin
          wdog_d  = 8'd0;
          state_d = ST_ERR;
        end else begin
          wdog_d  = wdog_q + 8'd1;
        end
      end
      ST_WR: begin
        if (pt_ack) begin
          wdog_d = 8'd0;
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + 6'd1;
            state_d = ST_RD;
          end
        end else if (wdog_q == WDOG_LAST) begin
          wdog_d  = 8'd0;
          state_d = ST_ERR;
        end else begin
          wdog_d  = wdog_q + 8'd1;
        end
      end
      ST_DONE, ST_ERR: begin
        wdog_d  = 8'd0;
        state_d = ST_IDLE;
      end
      default: begin
        wdog_d  = 8'd0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sequencer registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= 6'd0;
      wdog_q  <= 8'd0;
      byte_q  <= 8'd0;
      src_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wdog_q  <= wdog_d;
      byte_q  <= byte_d;
      src_q   <= src_d;
    end
  end

  oc8051_pt_bus_mux u_bus_mux (
    .loader_own_i (busy),
    .ld_stb_i     (ld_stb),
    .ld_addr_i    (ld_addr),
    .ld_data_i    (ld_data),
    .ld_priv_i    (ld_stb),
    .cpu_stb_i    (cpu_stb),
    .cpu_addr_i   (cpu_addr),
    .cpu_data_i   (cpu_data),
    .cpu_priv_i   (cpu_priv),
    .cpu_ack_o    (cpu_ack),
    .pt_stb_o     (pt_stb),
    .pt_addr_o    (pt_addr),
    .pt_data_o    (pt_data),
    .pt_priv_o    (pt_priv),
    .pt_ack_i     (pt_ack)
  );

endmodule
`default_nettype wire

// File: tb/tb_oc8051_pt_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_oc8051_pt_loader
// Purpose  : Self-checking bench for the page-table bulk loader. A
//            transaction-level model predicts every cycle's outputs; XRAM and
//            page-table responders are bench-driven; directed scenarios add
//            hand-computed literal expectations.
// Revision : 1.0  initial release
// ============================================================================
module tb_oc8051_pt_loader;

  localparam int          N    = 64;
  localparam logic [15:0] BASE = 16'hff80;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [15:0] src_base;
  logic        busy, done, err;
  logic        mem_stb;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_ack;
  logic        cpu_stb, cpu_priv, cpu_ack;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data;
  logic        pt_stb, pt_priv, pt_ack;
  logic [15:0] pt_addr;
  logic [7:0]  pt_data;

  int errors = 0;
  int checks = 0;

  logic [7:0] xmem [0:65535];
  logic [7:0] ptm  [0:63];

  int mem_delay = 0;
  int mem_wait  = 0;
  int stall_idx = -1;

  bit          chk_en = 1'b0;
  int          cyc = 0;
  int          start_cyc = -1, done_cyc = -1, err_cyc = -1, wr5_cyc = -1;
  int          done_cnt = 0, rd_hs = 0, wrap_hs = -1;

  // model: busy flag, phase 0=read 1=write 2=done 3=err, byte index, source
  bit          m_busy = 1'b0;
  int          m_phase = 0;
  int          m_idx = 0;
  int          m_wait = 0;
  logic [15:0] m_src = 16'h0;

  oc8051_pt_loader dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .src_base (src_base),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .mem_stb  (mem_stb),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .mem_ack  (mem_ack),
    .cpu_stb  (cpu_stb),
    .cpu_addr (cpu_addr),
    .cpu_data (cpu_data),
    .cpu_priv (cpu_priv),
    .cpu_ack  (cpu_ack),
    .pt_stb   (pt_stb),
    .pt_addr  (pt_addr),
    .pt_data  (pt_data),
    .pt_priv  (pt_priv),
    .pt_ack   (pt_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Inputs change 2 time units after the active edge
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // XRAM and page-table responders
  always @(negedge clk) begin
    if (mem_stb) begin
      if (mem_wait >= mem_delay) begin
        mem_ack  = 1'b1;
        mem_data = xmem[mem_addr];
        mem_wait = 0;
      end else begin
        mem_ack  = 1'b0;
        mem_wait = mem_wait + 1;
      end
    end else begin
      mem_ack  = 1'b0;
      mem_wait = 0;
    end
    pt_ack = pt_stb && !(stall_idx >= 0 && busy && pt_addr == 16'(BASE + stall_idx));
  end

  // Per-cycle compare against the transaction model, then advance the model
  always @(negedge clk) begin
    #1;
    cyc++;
    if (chk_en) begin
      chk("stb_excl", {31'd0, mem_stb & pt_stb}, 32'd0);
      chk("busy", {31'd0, busy}, {31'd0, m_busy});
      chk("done", {31'd0, done}, {31'd0, m_busy && m_phase == 2});
      chk("err", {31'd0, err}, {31'd0, m_busy && m_phase == 3});
      chk("mem_stb", {31'd0, mem_stb}, {31'd0, m_busy && m_phase == 0});
      if (!m_busy) begin
        chk("pass_stb", {31'd0, pt_stb}, {31'd0, cpu_stb});
        chk("pass_addr", {16'd0, pt_addr}, {16'd0, cpu_addr});
        chk("pass_data", {24'd0, pt_data}, {24'd0, cpu_data});
        chk("pass_priv", {31'd0, pt_priv}, {31'd0, cpu_priv});
        chk("pass_ack", {31'd0, cpu_ack}, {31'd0, pt_ack});
      end else begin
        chk("cpu_ack_busy", {31'd0, cpu_ack}, 32'd0);
        chk("pt_stb", {31'd0, pt_stb}, {31'd0, m_phase == 1});
        if (m_phase == 0)
          chk("mem_addr", {16'd0, mem_addr}, {16'd0, 16'(m_src + m_idx)});
        if (m_phase == 1) begin
          chk("pt_addr", {16'd0, pt_addr}, {16'd0, 16'(BASE + m_idx)});
          chk("pt_data", {24'd0, pt_data}, {24'd0, xmem[16'(m_src + m_idx)]});
          chk("pt_priv", {31'd0, pt_priv}, 32'd1);
        end
      end

      if (pt_stb && pt_ack && pt_addr[15:6] == 10'h3fe) ptm[pt_addr[5:0]] = pt_data;
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (err) err_cyc = cyc;
      if (busy && pt_stb && pt_addr == 16'(BASE + 5) && wr5_cyc < 0) wr5_cyc = cyc;
      if (mem_stb && mem_addr == 16'h0000 && wrap_hs < 0) wrap_hs = rd_hs;
      if (mem_stb && mem_ack) rd_hs++;

      if (rst) begin
        m_busy = 1'b0;
      end else if (!m_busy) begin
        if (start) begin
          m_busy = 1'b1; m_phase = 0; m_idx = 0; m_wait = 0;
          m_src = src_base; start_cyc = cyc;
        end
      end else begin
        case (m_phase)
          0: if (mem_ack) begin m_phase = 1; m_wait = 0; end
             else begin m_wait++; if (m_wait == 255) m_phase = 3; end
          1: if (pt_ack) begin
               m_wait = 0;
               if (m_idx == N - 1) m_phase = 2;
               else begin m_idx++; m_phase = 0; end
             end else begin m_wait++; if (m_wait == 255) m_phase = 3; end
          default: m_busy = 1'b0;
        endcase
      end
    end
  end

  task automatic run_load(input logic [15:0] src);
    src_base = src;
    start    = 1'b1;
    step();
    start    = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (busy && k < budget) begin step(); k++; end
    chk("wait_idle", {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_wr(input int idx, input int budget);
    int k = 0;
    while (!(busy && pt_stb && pt_addr == 16'(BASE + idx)) && k < budget) begin step(); k++; end
    chk("wait_wr", {31'd0, k < budget}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    rst = 1'b1; start = 1'b0; src_base = 16'h0;
    cpu_stb = 1'b0; cpu_addr = 16'h0; cpu_data = 8'h0; cpu_priv = 1'b0;
    mem_ack = 1'b0; mem_data = 8'h0; pt_ack = 1'b0;
    for (int i = 0; i < N; i++) ptm[i] = 8'h00;
    step(); step();
    chk_en = 1'b1;
    step();
    rst = 1'b0;
    // reset state
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_mem_stb", {31'd0, mem_stb}, 32'd0);
    chk("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
    step();

    // 1: image i+1 at 2000, same-cycle acks
    for (int i = 0; i < N; i++) xmem[16'(16'h2000 + i)] = 8'(i + 1);
    done_cnt = 0;
    run_load(16'h2000);
    wait_idle(400);
    chk("t1_latency", 32'(done_cyc - start_cyc), 32'd129);
    chk("t1_done_cnt", 32'(done_cnt), 32'd1);
    chk("t1_pt_first", {24'd0, ptm[0]}, 32'h01);
    chk("t1_pt_last", {24'd0, ptm[63]}, 32'h40);

    // 2: XRAM ack delayed 3 cycles per byte
    for (int i = 0; i < N; i++) xmem[16'(16'h3000 + i)] = 8'(i * 3 + 7);
    mem_delay = 3; done_cnt = 0;
    run_load(16'h3000);
    wait_idle(1000);
    mem_delay = 0;
    chk("t2_latency", 32'(done_cyc - start_cyc), 32'd321);
    chk("t2_done_cnt", 32'(done_cnt), 32'd1);
    chk("t2_pt10", {24'd0, ptm[10]}, 32'd37);

    // 3: page table never acks idx 5
    for (int i = 0; i < N; i++) begin xmem[16'(16'h5000 + i)] = 8'(8'h80 + i); ptm[i] = 8'hee; end
    stall_idx = 5; wr5_cyc = -1; err_cyc = -1; done_cnt = 0;
    run_load(16'h5000);
    wait_idle(1000);
    stall_idx = -1;
    chk("t3_err_delay", 32'(err_cyc - wr5_cyc), 32'd255);
    chk("t3_pt4", {24'd0, ptm[4]}, 32'h84);
    chk("t3_pt5", {24'd0, ptm[5]}, 32'hee);
    chk("t3_no_done", 32'(done_cnt), 32'd0);

    // 4: CPU holds a write to FF81 across a load
    cpu_stb = 1'b1; cpu_addr = 16'hff81; cpu_data = 8'ha5; cpu_priv = 1'b0;
    run_load(16'h2000);
    repeat (10) step();
    chk("t4_cpu_ack_busy", {31'd0, cpu_ack}, 32'd0);
    wait_idle(400);
    step();
    chk("t4_cpu_ack_idle", {31'd0, cpu_ack}, 32'd1);
    chk("t4_pt_addr_idle", {16'd0, pt_addr}, 32'hff81);
    step();
    chk("t4_pt1", {24'd0, ptm[1]}, 32'ha5);
    cpu_stb = 1'b0; cpu_addr = 16'h0; cpu_data = 8'h0;

    // 5: source image wraps FFFF -> 0000
    for (int i = 0; i < N; i++) xmem[16'(16'hffe0 + i)] = 8'(8'hc0 ^ i);
    wrap_hs = -1; rd_hs = 0;
    run_load(16'hffe0);
    wait_idle(400);
    chk("t5_wrap_idx", 32'(wrap_hs), 32'd32);
    chk("t5_pt31", {24'd0, ptm[31]}, 32'hdf);
    chk("t5_pt32", {24'd0, ptm[32]}, 32'he0);

    // 6: start while busy is ignored; reset mid-load returns to idle
    for (int i = 0; i < N; i++) xmem[16'(16'h4000 + i)] = 8'(i);
    run_load(16'h4000);
    wait_wr(3, 50);
    run_load(16'h1234);
    wait_wr(10, 80);
    rst = 1'b1;
    step();
    chk("t6_busy", {31'd0, busy}, 32'd0);
    chk("t6_mem_stb", {31'd0, mem_stb}, 32'd0);
    chk("t6_pt_stb", {31'd0, pt_stb}, 32'd0);
    rst = 1'b0;
    step(); step();
    chk("t6_still_idle", {31'd0, busy}, 32'd0);

    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
